regs_forward_sb: RTL and testbench

Operand forwarding and hazard unit for the decode stage, the parametrised successor of the single-cycle forward/stall logic. It resolves each read port against a configurable number of younger pipeline stages, each with several write ports, and tracks long-latency register writes (mul/div, load miss) in an in-order pending table. It forwards data when it exists anywhere in flight and stalls decode when it does not. It sits between the register file read ports and the ID/EX pipeline register.

---
 rtl/regs_forward_sb_pkg.sv | 17 +
 rtl/regs_pend_table.sv | 89 ++++++++
 rtl/regs_forward_sb.sv | 94 +++++++++
 tb/tb_regs_forward_sb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regs_forward_sb_pkg.sv
// Shared types for the decode-stage forwarding/hazard unit.
package regs_forward_sb_pkg;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] uint32_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t waddr;
  } pend_entry_t;

  typedef struct packed {
    logic      we;
    reg_addr_t waddr;
    uint32_t   wrdata;
    logic      ready;
  } fwd_bus_t;
endpackage

// File: rtl/regs_pend_table.sv
// In-order table of outstanding long-latency register writes with
// per-read-port match and sole-head-match detection.
module regs_pend_table
  import regs_forward_sb_pkg::*;
#(
  parameter int READ_PORTS = 2,
  parameter int PEND_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [4:0]                push_waddr_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [READ_PORTS-1:0][4:0] raddr_i,
  output logic [READ_PORTS-1:0]     match_o,
  output logic [READ_PORTS-1:0]     head_only_o,
  output logic                      full_o,
  output logic                      err_o
);
  localparam int PW = $clog2(PEND_DEPTH);
  localparam int CW = PW + 1;

  pend_entry_t tbl_q [PEND_DEPTH];
  pend_entry_t tbl_d [PEND_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          empty, push_ok, pop_ok;
  logic [READ_PORTS-1:0][PEND_DEPTH-1:0] hit;

  assign full_o  = (cnt_q == CW'(PEND_DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty;
  assign err_o   = err_q;

  // Both accepted implies 0 < count < depth, so wr and rd never collide.
  always_comb begin
    tbl_d = tbl_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (flush_i) begin
      for (int i = 0; i < PEND_DEPTH; i++) tbl_d[i] = '0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      err_d = err_q | (push_i & full_o) | (pop_i & empty);
      if (push_ok) begin
        tbl_d[wr_q] = '{valid: 1'b1, waddr: push_waddr_i};
        wr_d        = wr_q + 1'b1;
      end
      if (pop_ok) begin
        tbl_d[rd_q].valid = 1'b0;
        rd_d              = rd_q + 1'b1;
      end
      if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PEND_DEPTH; i++) tbl_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      tbl_q <= tbl_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      for (int i = 0; i < PEND_DEPTH; i++)
        hit[p][i] = tbl_q[i].valid && (tbl_q[i].waddr == raddr_i[p]) && (raddr_i[p] != '0);
      match_o[p]     = |hit[p];
      head_only_o[p] = (hit[p] == (PEND_DEPTH'(1) << rd_q));
    end
  end
endmodule

// File: rtl/regs_forward_sb.sv
// Decode operand forwarding and hazard resolution over in-flight stages and
// the pending long-latency table. Macro REGS_FWD_CMPL_BYPASS_EN enables the
// same-cycle completion bypass on a sole head match.
module regs_forward_sb
  import regs_forward_sb_pkg::*;
#(
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int FWD_STAGES  = 2,
  parameter int PEND_DEPTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [READ_PORTS-1:0][4:0]                   regs_raddr_i,
  input  logic [READ_PORTS-1:0][31:0]                  regs_rddata_i,
  input  logic [FWD_STAGES-1:0][WRITE_PORTS-1:0]       fwd_we_i,
  input  logic [FWD_STAGES-1:0][WRITE_PORTS-1:0][4:0]  fwd_waddr_i,
  input  logic [FWD_STAGES-1:0][WRITE_PORTS-1:0][31:0] fwd_wrdata_i,
  input  logic [FWD_STAGES-1:0][WRITE_PORTS-1:0]       fwd_ready_i,
  input  logic                                         pend_req_i,
  input  logic [4:0]                                   pend_waddr_i,
  input  logic                                         cmpl_valid_i,
  input  logic [31:0]                                  cmpl_wrdata_i,
  input  logic                                         flush_i,
  output logic [READ_PORTS-1:0][31:0]                  regs_rddata_o,
  output logic                                         stall_o,
  output logic                                         pend_full_o,
  output logic                                         pend_err_o
);
  logic [READ_PORTS-1:0] pmatch, phead, port_stall;
  fwd_bus_t              bus;
  logic                  shit, srdy;
  uint32_t               sdat;

  regs_pend_table #(.READ_PORTS(READ_PORTS), .PEND_DEPTH(PEND_DEPTH)) u_pend (
    .clk          (clk),
    .rst          (rst),
    .push_i       (pend_req_i),
    .push_waddr_i (pend_waddr_i),
    .pop_i        (cmpl_valid_i),
    .flush_i      (flush_i),
    .raddr_i      (regs_raddr_i),
    .match_o      (pmatch),
    .head_only_o  (phead),
    .full_o       (pend_full_o),
    .err_o        (pend_err_o)
  );

`ifndef REGS_FWD_CMPL_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{cmpl_wrdata_i, phead};
`endif

  // Scan oldest stage / lowest port first so the youngest, highest port hit lands last.
  always_comb begin
    bus  = '0;
    shit = 1'b0;
    srdy = 1'b0;
    sdat = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      regs_rddata_o[p] = regs_rddata_i[p];
      port_stall[p]    = 1'b0;
      shit = 1'b0;
      srdy = 1'b0;
      sdat = '0;
      for (int s = FWD_STAGES - 1; s >= 0; s--) begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
          bus = '{we: fwd_we_i[s][w], waddr: fwd_waddr_i[s][w],
                  wrdata: fwd_wrdata_i[s][w], ready: fwd_ready_i[s][w]};
          if (bus.we && bus.waddr == regs_raddr_i[p]) begin
            shit = 1'b1;
            srdy = bus.ready;
            sdat = bus.wrdata;
          end
        end
      end
      if (regs_raddr_i[p] != '0) begin
        if (shit) begin
          if (srdy) regs_rddata_o[p] = sdat;
          else      port_stall[p]    = 1'b1;
        end else if (pmatch[p]) begin
`ifdef REGS_FWD_CMPL_BYPASS_EN
          if (phead[p] && cmpl_valid_i) regs_rddata_o[p] = cmpl_wrdata_i;
          else                          port_stall[p]    = 1'b1;
`else
          port_stall[p] = 1'b1;
`endif
        end
      end
    end
  end

  assign stall_o = |port_stall;
endmodule

// File: tb/tb_regs_forward_sb.sv
// Bench for regs_forward_sb: directed plan plus random traffic against a
// queue-based reference model.
module tb_regs_forward_sb;
  localparam int RP = 2, WP = 1, FS = 2, PD = 4;

  logic clk = 1'b0, rst;
  logic [RP-1:0][4:0]          raddr;
  logic [RP-1:0][31:0]         rdd, rd_o;
  logic [FS-1:0][WP-1:0]       fwe, frdy;
  logic [FS-1:0][WP-1:0][4:0]  fwa;
  logic [FS-1:0][WP-1:0][31:0] fwd;
  logic pend_req, cmpl, flush, stall, full, err;
  logic [4:0]  pwa;
  logic [31:0] cdat;

  int n_tests = 0, n_fail = 0;
  logic [4:0] pq[$];
  logic       m_err;

  always #5 clk = ~clk;

  regs_forward_sb #(.READ_PORTS(RP), .WRITE_PORTS(WP), .FWD_STAGES(FS), .PEND_DEPTH(PD)) dut (
    .clk(clk), .rst(rst), .regs_raddr_i(raddr), .regs_rddata_i(rdd),
    .fwd_we_i(fwe), .fwd_waddr_i(fwa), .fwd_wrdata_i(fwd), .fwd_ready_i(frdy),
    .pend_req_i(pend_req), .pend_waddr_i(pwa), .cmpl_valid_i(cmpl),
    .cmpl_wrdata_i(cdat), .flush_i(flush), .regs_rddata_o(rd_o),
    .stall_o(stall), .pend_full_o(full), .pend_err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: priority scan from the spec rules over the pending queue.
  task automatic model_out(output logic [RP-1:0][31:0] ed, output logic [RP-1:0] es);
    bit done;
    int n;
    for (int p = 0; p < RP; p++) begin
      ed[p] = rdd[p];
      es[p] = 1'b0;
      done  = 0;
      n     = 0;
      if (raddr[p] != 0) begin
        for (int s = 0; s < FS; s++)
          for (int w = WP - 1; w >= 0; w--)
            if (!done && fwe[s][w] && fwa[s][w] == raddr[p]) begin
              done = 1;
              if (frdy[s][w]) ed[p] = fwd[s][w];
              else            es[p] = 1'b1;
            end
        if (!done) begin
          foreach (pq[i]) if (pq[i] == raddr[p]) n++;
          if (n > 0) begin
            es[p] = 1'b1;
`ifdef REGS_FWD_CMPL_BYPASS_EN
            if (n == 1 && pq[0] == raddr[p] && cmpl) begin
              es[p] = 1'b0;
              ed[p] = cdat;
            end
`endif
          end
        end
      end
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      pq.delete();
      m_err = 1'b0;
    end else if (flush) begin
      pq.delete();
    end else begin
      if (pend_req && pq.size() == PD) m_err = 1'b1;
      if (cmpl && pq.size() == 0)      m_err = 1'b1;
      if (pend_req && pq.size() < PD) begin
        if (cmpl && pq.size() > 0) void'(pq.pop_front());
        pq.push_back(pwa);
      end else if (cmpl && pq.size() > 0) begin
        void'(pq.pop_front());
      end
    end
  endtask

  // Called just after negedge with inputs set: check, then clock the model.
  task automatic step(input string tag);
    logic [RP-1:0][31:0] ed;
    logic [RP-1:0]       es;
    #1;
    model_out(ed, es);
    for (int p = 0; p < RP; p++)
      if (!es[p]) chk($sformatf("%s_data%0d", tag, p), rd_o[p], ed[p]);
    chk({tag, "_stall"}, {31'b0, stall}, {31'b0, |es});
    chk({tag, "_full"},  {31'b0, full},  {31'b0, pq.size() == PD});
    chk({tag, "_err"},   {31'b0, err},   {31'b0, m_err});
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; raddr = {5'd4, 5'd3}; rdd = {32'h22, 32'h11};
    fwe = '0; fwa = '0; fwd = '0; frdy = '0;
    pend_req = 0; pwa = 0; cmpl = 0; cdat = 0; flush = 0;
  endtask

  task automatic push(input logic [4:0] a);
    idle(); pend_req = 1; pwa = a; step("push");
  endtask

  initial begin
    idle();
    rst = 1; m_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("rst_p0", rd_o[0], 32'h11);
    chk("rst_p1", rd_o[1], 32'h22);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    step("rst");

    // Stage priority
    fwe[0][0] = 1; fwa[0][0] = 3; fwd[0][0] = 32'hA; frdy[0][0] = 1;
    fwe[1][0] = 1; fwa[1][0] = 3; fwd[1][0] = 32'hB; frdy[1][0] = 1;
    #1 chk("stg_prio", rd_o[0], 32'hA);
    step("stg");
    fwe[0][0] = 1; fwa[0][0] = 3; frdy[0][0] = 0;
    fwe[1][0] = 1; fwa[1][0] = 3; fwd[1][0] = 32'hB; frdy[1][0] = 1;
    #1 chk("stg_notrdy", {31'b0, stall}, 32'd1);
    step("stg_nr");

    // Single pending write and completion
    push(5);
    idle(); raddr[0] = 5; step("pend_hit");
    idle(); raddr[0] = 5; cmpl = 1; cdat = 32'h55; step("cmpl");
    idle(); raddr[0] = 5; rdd[0] = 32'h77;
    #1 chk("after_cmpl", rd_o[0], 32'h77);
    step("after_cmpl");

    // Two entries to the same register
    push(5); push(5);
    idle(); raddr[0] = 5; cmpl = 1; cdat = 32'h1;
    #1 chk("dup_stall", {31'b0, stall}, 32'd1);
    step("dup1");
    idle(); raddr[0] = 5; cmpl = 1; cdat = 32'h2; step("dup2");
    idle(); raddr[0] = 5; step("dup_done");

    // Fill, overflow, push+pop from full
    push(1); push(2); push(6); push(7);
    idle(); #1 chk("full", {31'b0, full}, 32'd1);
    push(8);
    idle(); pend_req = 1; pwa = 9; cmpl = 1; step("pushpop_full");
    idle(); raddr = {5'd9, 5'd2}; step("cnt3");

    // Flush with simultaneous push
    idle(); flush = 1; pend_req = 1; pwa = 3; step("flush");
    idle(); raddr = {5'd6, 5'd7}; step("post_flush");
    idle(); raddr = {5'd0, 5'd0}; pend_req = 1; pwa = 0; step("r0_push");
    idle(); raddr = {5'd0, 5'd0}; step("r0_read");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      pend_req = ($urandom_range(0, 2) == 0);
      cmpl     = ($urandom_range(0, 2) == 0);
      pwa      = 5'($urandom_range(0, 7));
      cdat     = $urandom;
      for (int p = 0; p < RP; p++) begin
        raddr[p] = 5'($urandom_range(0, 7));
        rdd[p]   = $urandom;
      end
      for (int s = 0; s < FS; s++)
        for (int w = 0; w < WP; w++) begin
          fwe[s][w]  = ($urandom_range(0, 3) == 0);
          fwa[s][w]  = 5'($urandom_range(0, 7));
          fwd[s][w]  = $urandom;
          frdy[s][w] = ($urandom_range(0, 3) != 0);
        end
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
